prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Streams programs into the array's per-core program stores and sequences core
//  reset around the load. Sits between the host/config stream and the core
//  array; drives each core's prog[] word writes, pLength and rst.
//  Cores stay in reset while loading and are released by a RUN command.
// PARAMETERS
//  N_CORES  4   number of cores addressed (1..256)
//  MAX_LEN  15  program words per core; addr counter is 4 bits
//  CW       $clog2(N_CORES), min 1: width of core select (localparam)
// PORTS
//  clk       in   1   clock
//  rst_n     in   1   asynchronous, active-low reset
//  in_valid  in   1   stream word valid
//  in_data   in   16  stream word
//  in_ready  out  1   word accepted when in_valid & in_ready
//  wr_en     out  1   program word write strobe (one cycle)
//  wr_core   out  CW  target core for wr_en / len_we
//  wr_addr   out  4   program slot 0..MAX_LEN-1
//  wr_data   out  16  program word
//  len_we    out  1   pLength write strobe for wr_core
//  len_data  out  4   pLength value 1..MAX_LEN
//  core_rst  out  1   active-high reset to all cores
//  running   out  1   high in RUN
//  err       out  1   high in ERR
// BEHAVIOUR
//  Header word: [15:12] cmd, [11:4] core index, [3:0] length.
//   cmd 4'hA = LOAD (idx < N_CORES, len 1..MAX_LEN); 4'hF = RUN; 16'hE000 = SYNC.
//  All outputs registered. Reset values: core_rst=1; all other outputs 0;
//   state=CLEAR, counters 0.
//  States:
//   CLEAR: in_ready=0. Walks core 0..N_CORES-1, addr 0..MAX_LEN-1.
//    Per cycle: wr_en=1 with wr_data=16'h7FFF (NOP).
//    Also len_we=1 with len_data=1 on addr 0 of each core.
//    Takes N_CORES*MAX_LEN cycles, then -> HDR.
//   HDR: in_ready=1, core_rst=1. On accepted word:
//    valid LOAD: len_we=1 next cycle; latch core/len; addr<=0; -> DATA.
//    RUN: -> RUN.
//    SYNC: stay in HDR.
//    anything else, idx>=N_CORES or len==0: -> ERR.
//   DATA: in_ready=1. Each accepted word appears on the next cycle as
//    wr_en=1, wr_addr=addr, wr_data=word; then addr++.
//    Word with addr==len-1 -> HDR. Data words are not decoded, so SYNC/RUN
//    patterns are data here. No time-out; in_valid gaps simply pause.
//   RUN: core_rst=0 from the cycle after RUN is accepted; running=1; in_ready=1.
//    SYNC -> CLEAR: core_rst=1 next cycle; all stores re-cleared.
//    Other words discarded.
//   ERR: err=1, core_rst=1, in_ready=1. Words discarded until SYNC -> HDR
//    with err cleared. No re-clear.
//  Latency: accepted word -> write strobe exactly 1 cycle; max 1 write/cycle.
//  Reloading a core overwrites slots 0..len-1. Higher slots keep stale data,
//   unreachable because pLength is rewritten.
//  Cores never loaded keep NOP, pLength=1.
//  rst_n low mid-operation: immediate abandon, outputs to reset values.
//   Full CLEAR after release. Partial writes are lost.
//  wr_en and len_we are mutually exclusive except in CLEAR at addr 0.
// TESTING
//  1 rst_n pulse, N_CORES=4 -> in_ready=0 for exactly 60 cycles.
//    60 wr_en (data 16'h7FFF) and 4 len_we (1); core_rst=1 throughout.
//  2 Send A013,1234,5678,F000 -> len_we core1 len3.
//    Writes (1,0,1234),(1,1,5678),(1,2,<next word>).
//    F000 is data, so no RUN yet. Then F000 -> core_rst=0 next cycle, running=1.
//  3 Header A050 (idx 5 >= 4) -> err=1, core_rst=1; A011 discarded.
//    E000 -> err=0, HDR; A011,7FFC accepted -> one write (1,0,7FFC).
//  4 Valid gaps of 3 idle cycles inside DATA -> no spurious wr_en, addr holds.
//    Write order is unchanged.
//  5 rst_n asserted after 1 of 3 DATA words -> core_rst=1, wr_en=0 immediately.
//    On release, a full CLEAR runs, then HDR.
//  6 RUN, then E000 -> core_rst=1 next cycle, in_ready=0 for 60-cycle CLEAR.

Source files
------------

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - host stream and core-array program write bus for prog_loader
interface prog_loader_if #(
  parameter int N_CORES = 4
);
  localparam int CW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  logic          in_valid;
  logic [15:0]   in_data;
  logic          in_ready;
  logic          wr_en;
  logic [CW-1:0] wr_core;
  logic [3:0]    wr_addr;
  logic [15:0]   wr_data;
  logic          len_we;
  logic [3:0]    len_data;
  logic          core_rst;
  logic          running;
  logic          err;

  // master = host side driving the stream and observing the array writes
  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_core, wr_addr, wr_data,
    input  len_we, len_data, core_rst, running, err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_core, wr_addr, wr_data,
    output len_we, len_data, core_rst, running, err
  );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams programs into per-core stores and sequences core reset
module prog_loader #(
  parameter int N_CORES = 4,
  parameter int MAX_LEN = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  prog_loader_if.slave bus
);
  localparam int CW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam logic [15:0] NOP_WORD  = 16'h7FFF;
  localparam logic [15:0] SYNC_WORD = 16'hE000;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_HDR,
    S_DATA,
    S_RUN,
    S_ERR
  } state_t;

  state_t        state_q;
  logic [CW-1:0] core_q;
  logic [3:0]    addr_q;
  logic [3:0]    len_q;

  logic          in_ready_q;
  logic          wr_en_q;
  logic [CW-1:0] wr_core_q;
  logic [3:0]    wr_addr_q;
  logic [15:0]   wr_data_q;
  logic          len_we_q;
  logic [3:0]    len_data_q;
  logic          core_rst_q;
  logic          running_q;
  logic          err_q;

  logic       acc;
  logic [3:0] hdr_cmd;
  logic [7:0] hdr_idx;
  logic [3:0] hdr_len;
  logic       is_sync;
  logic       load_ok;

  assign acc     = bus.in_valid & in_ready_q;
  assign hdr_cmd = bus.in_data[15:12];
  assign hdr_idx = bus.in_data[11:4];
  assign hdr_len = bus.in_data[3:0];
  assign is_sync = (bus.in_data == SYNC_WORD);
  assign load_ok = (hdr_cmd == 4'hA) && ({1'b0, hdr_idx} < 9'(N_CORES)) &&
                   (hdr_len != 4'd0) && (hdr_len <= 4'(MAX_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      core_q     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_core_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      len_we_q   <= 1'b0;
      len_data_q <= '0;
      core_rst_q <= 1'b1;
      running_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_en_q  <= 1'b0;
      len_we_q <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          // one NOP per cycle; pLength is reset alongside slot 0 of each core
          wr_en_q    <= 1'b1;
          wr_core_q  <= core_q;
          wr_addr_q  <= addr_q;
          wr_data_q  <= NOP_WORD;
          len_we_q   <= (addr_q == 4'd0);
          len_data_q <= 4'd1;
          if (addr_q == 4'(MAX_LEN - 1)) begin
            addr_q <= '0;
            if (core_q == CW'(N_CORES - 1)) begin
              core_q     <= '0;
              state_q    <= S_HDR;
              in_ready_q <= 1'b1;
            end else begin
              core_q <= core_q + CW'(1);
            end
          end else begin
            addr_q <= addr_q + 4'd1;
          end
        end
        S_HDR: begin
          if (acc) begin
            if (is_sync) begin
              state_q <= S_HDR;
            end else if (hdr_cmd == 4'hF) begin
              state_q    <= S_RUN;
              core_rst_q <= 1'b0;
              running_q  <= 1'b1;
            end else if (load_ok) begin
              len_we_q   <= 1'b1;
              wr_core_q  <= hdr_idx[CW-1:0];
              len_data_q <= hdr_len;
              core_q     <= hdr_idx[CW-1:0];
              len_q      <= hdr_len;
              addr_q     <= '0;
              state_q    <= S_DATA;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        S_DATA: begin
          // payload is written verbatim; command patterns carry no meaning here
          if (acc) begin
            wr_en_q   <= 1'b1;
            wr_core_q <= core_q;
            wr_addr_q <= addr_q;
            wr_data_q <= bus.in_data;
            if (addr_q == len_q - 4'd1) begin
              addr_q  <= '0;
              state_q <= S_HDR;
            end else begin
              addr_q <= addr_q + 4'd1;
            end
          end
        end
        S_RUN: begin
          if (acc && is_sync) begin
            state_q    <= S_CLEAR;
            core_rst_q <= 1'b1;
            running_q  <= 1'b0;
            in_ready_q <= 1'b0;
            core_q     <= '0;
            addr_q     <= '0;
          end
        end
        S_ERR: begin
          if (acc && is_sync) begin
            state_q <= S_HDR;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_CLEAR;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_core  = wr_core_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.len_we   = len_we_q;
  assign bus.len_data = len_data_q;
  assign bus.core_rst = core_rst_q;
  assign bus.running  = running_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized and directed bench for prog_loader against a behavioural model
module tb_prog_loader;
  localparam int N   = 4;
  localparam int MAX = 15;
  localparam logic [15:0] NOP  = 16'h7FFF;
  localparam logic [15:0] SYNC = 16'hE000;

  localparam int M_CLR = 0, M_HDR = 1, M_DATA = 2, M_RUN = 3, M_ERR = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prog_loader_if #(.N_CORES(N)) bus ();

  prog_loader #(.N_CORES(N), .MAX_LEN(MAX)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // expected program stores and what the DUT actually wrote
  logic [15:0] exp_mem [N][MAX];
  int          exp_len [N];
  logic [15:0] obs_mem [N][MAX];
  int          obs_len [N];

  int   m_mode, m_ci, m_core, m_len, m_addr;
  logic e_in_ready, e_wr_en, e_len_we, e_core_rst, e_running, e_err;
  int   e_wr_core, e_wr_addr, e_len_data;
  logic [15:0] e_wr_data;

  task automatic model_reset();
    m_mode = M_CLR; m_ci = 0; m_core = 0; m_len = 0; m_addr = 0;
    e_in_ready = 0; e_wr_en = 0; e_len_we = 0;
    e_core_rst = 1; e_running = 0; e_err = 0;
  endtask

  // model: one step per clock from the stream rules, with a linear clear index
  initial begin
    logic acc;
    logic [15:0] w;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        acc = bus.in_valid && e_in_ready;
        w = bus.in_data;
        e_wr_en = 0;
        e_len_we = 0;
        if (m_mode == M_CLR) begin
          e_wr_en = 1; e_wr_core = m_ci / MAX; e_wr_addr = m_ci % MAX; e_wr_data = NOP;
          exp_mem[e_wr_core][e_wr_addr] = NOP;
          if (e_wr_addr == 0) begin
            e_len_we = 1; e_len_data = 1; exp_len[e_wr_core] = 1;
          end
          m_ci++;
          if (m_ci == N * MAX) begin
            m_ci = 0; m_mode = M_HDR; e_in_ready = 1;
          end
        end else if (m_mode == M_HDR && acc) begin
          if (w == SYNC) begin
            m_mode = M_HDR;
          end else if (w[15:12] == 4'hF) begin
            m_mode = M_RUN; e_core_rst = 0; e_running = 1;
          end else if (w[15:12] == 4'hA && int'(w[11:4]) < N && w[3:0] >= 1 && int'(w[3:0]) <= MAX) begin
            m_core = int'(w[11:4]); m_len = int'(w[3:0]); m_addr = 0;
            e_len_we = 1; e_wr_core = m_core; e_len_data = m_len; exp_len[m_core] = m_len;
            m_mode = M_DATA;
          end else begin
            m_mode = M_ERR; e_err = 1;
          end
        end else if (m_mode == M_DATA && acc) begin
          e_wr_en = 1; e_wr_core = m_core; e_wr_addr = m_addr; e_wr_data = w;
          exp_mem[m_core][m_addr] = w;
          m_addr++;
          if (m_addr == m_len) m_mode = M_HDR;
        end else if (m_mode == M_RUN && acc && w == SYNC) begin
          m_mode = M_CLR; m_ci = 0; e_core_rst = 1; e_running = 0; e_in_ready = 0;
        end else if (m_mode == M_ERR && acc && w == SYNC) begin
          m_mode = M_HDR; e_err = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", 32'(bus.in_ready), 32'(e_in_ready));
      chk("wr_en", 32'(bus.wr_en), 32'(e_wr_en));
      chk("len_we", 32'(bus.len_we), 32'(e_len_we));
      chk("core_rst", 32'(bus.core_rst), 32'(e_core_rst));
      chk("running", 32'(bus.running), 32'(e_running));
      chk("err", 32'(bus.err), 32'(e_err));
      if (e_wr_en && bus.wr_en) begin
        chk("wr_core", 32'(bus.wr_core), 32'(e_wr_core));
        chk("wr_addr", 32'(bus.wr_addr), 32'(e_wr_addr));
        chk("wr_data", 32'(bus.wr_data), 32'(e_wr_data));
      end
      if (e_len_we && bus.len_we) begin
        chk("len_core", 32'(bus.wr_core), 32'(e_wr_core));
        chk("len_data", 32'(bus.len_data), 32'(e_len_data));
      end
      if (rst_n && bus.wr_en === 1'b1 && !$isunknown({bus.wr_core, bus.wr_addr}) && int'(bus.wr_addr) < MAX)
        obs_mem[bus.wr_core][bus.wr_addr] = bus.wr_data;
      if (rst_n && bus.len_we === 1'b1 && !$isunknown(bus.wr_core))
        obs_len[bus.wr_core] = int'(bus.len_data);
    end
  end

  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = w;
    while (bus.in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data = 16'($urandom);
    repeat (n) @(negedge clk);
  endtask

  // counts a CLEAR window: cycles with in_ready low plus the strobes inside it
  task automatic clear_window(output int zc, output int wc, output int lc, output int rb);
    zc = 0; wc = 0; lc = 0; rb = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.wr_en === 1'b1) wc++;
      if (bus.len_we === 1'b1) lc++;
      if (bus.in_ready === 1'b1) break;
      zc++;
      if (bus.core_rst !== 1'b1) rb++;
    end
  endtask

  task automatic check_clear(input string tag);
    int zc, wc, lc, rb;
    clear_window(zc, wc, lc, rb);
    chk({tag, "_ready_low_cycles"}, 32'(zc), 32'd60);
    chk({tag, "_nop_writes"}, 32'(wc), 32'd60);
    chk({tag, "_len_writes"}, 32'(lc), 32'd4);
    chk({tag, "_core_rst_dropped"}, 32'(rb), 32'd0);
  endtask

  initial begin
    #500000;
    chk("watchdog", 32'd1, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int r, c, l;
    logic [15:0] w;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_rst", 32'(bus.core_rst), 32'd1);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_running", 32'(bus.running), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    check_clear("boot");

    // load core 1 with three words; the trailing F000 is payload
    send(16'hA013); send(16'h1234); send(16'h5678); send(16'hF000);
    idle(2);
    chk("t2_w0", 32'(obs_mem[1][0]), 32'h1234);
    chk("t2_w1", 32'(obs_mem[1][1]), 32'h5678);
    chk("t2_w2", 32'(obs_mem[1][2]), 32'hF000);
    chk("t2_len", 32'(obs_len[1]), 32'd3);
    chk("t2_not_running", 32'(bus.running), 32'd0);
    send(16'hF000);
    @(negedge clk); #1;
    chk("t2_core_rst_low", 32'(bus.core_rst), 32'd0);
    chk("t2_running", 32'(bus.running), 32'd1);

    send(SYNC);
    check_clear("resync");
    chk("t6_w0_nop", 32'(obs_mem[1][0]), 32'(NOP));
    chk("t6_len_one", 32'(obs_len[1]), 32'd1);

    send(16'hA050);
    @(negedge clk); #1;
    chk("t3_err", 32'(bus.err), 32'd1);
    chk("t3_core_rst", 32'(bus.core_rst), 32'd1);
    send(16'hA011);
    send(SYNC);
    @(negedge clk); #1;
    chk("t3_err_clear", 32'(bus.err), 32'd0);
    send(16'hA011); send(16'h7FFC);
    idle(2);
    chk("t3_w0", 32'(obs_mem[1][0]), 32'h7FFC);
    chk("t3_w1_stale_nop", 32'(obs_mem[1][1]), 32'(NOP));
    chk("t3_len", 32'(obs_len[1]), 32'd1);

    send(16'hA023);
    send(16'hAAA1); idle(3);
    send(16'hBBB2); idle(3);
    send(16'hCCC3); idle(2);
    chk("t4_w0", 32'(obs_mem[2][0]), 32'hAAA1);
    chk("t4_w1", 32'(obs_mem[2][1]), 32'hBBB2);
    chk("t4_w2", 32'(obs_mem[2][2]), 32'hCCC3);

    send(16'hA033); send(16'h1111);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_wr_en", 32'(bus.wr_en), 32'd0);
    chk("t5_core_rst", 32'(bus.core_rst), 32'd1);
    chk("t5_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_clear("t5");
    chk("t5_w0_nop", 32'(obs_mem[3][0]), 32'(NOP));
    chk("t5_len_one", 32'(obs_len[3]), 32'd1);

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        c = $urandom_range(0, N - 1);
        l = $urandom_range(1, MAX);
        send({4'hA, 8'(c), 4'(l)});
        for (int i = 0; i < l; i++) begin
          send(16'($urandom));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
      end else if (r == 6) begin
        case ($urandom_range(0, 2))
          0: send({4'hA, 8'($urandom_range(N, 255)), 4'($urandom_range(1, 15))});
          1: send({4'hA, 8'($urandom_range(0, N - 1)), 4'h0});
          default: send({4'($urandom_range(1, 9)), 12'($urandom)});
        endcase
        repeat ($urandom_range(0, 2)) begin
          w = 16'($urandom);
          if (w == SYNC) w = 16'h0;
          send(w);
        end
        send(SYNC);
      end else if (r == 7) begin
        send(SYNC);
      end else begin
        send(16'hF000);
        repeat ($urandom_range(0, 2)) begin
          w = 16'($urandom);
          if (w == SYNC) w = 16'h0;
          send(w);
        end
        send(SYNC);
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    idle(3);

    for (int k = 0; k < N; k++) begin
      chk("final_len", 32'(obs_len[k]), 32'(exp_len[k]));
      for (int a = 0; a < MAX; a++)
        if (a < exp_len[k]) chk("final_mem", 32'(obs_mem[k][a]), 32'(exp_mem[k][a]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
